// File: rtl/updown_cmd_gen.sv
// Two-button up/down command generator for a 4-bit up/down counter.
// Each button is synchronized and debounced in its own lane; an FSM turns
// debounced presses into single step pulses with hold-to-auto-repeat and
// locks out when both buttons are active at once.

// Per-lane synchronizer + debouncer.
module updown_cmd_gen_db #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_sync,
  output logic o_db
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  // Two-flop synchronizer, then count consecutive mismatches against the debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_db   <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_db  <= ~r_db;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_sync = r_sync[1];
  assign o_db   = r_db;
endmodule

module updown_cmd_gen #(
  parameter int DB_CYCLES   = 16,
  parameter int HOLD_CYCLES = 64,   // must be >= 2 so steps never run back to back
  parameter int RPT_CYCLES  = 16    // must be >= 2 for the same reason
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_dn,
  output logic sel,
  output logic step,
  output logic locked
);
  localparam int NUM_LANES = 2;   // lane 0 = up, lane 1 = down
  localparam int TMAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] RPT_LAST  = TW'(RPT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UP_HOLD, S_DN_HOLD, S_UP_RPT, S_DN_RPT, S_LOCK
  } state_t;

  logic [NUM_LANES-1:0] w_raw, w_sync, w_db, w_rise, w_press;
  logic [NUM_LANES-1:0] r_lvl, r_lvl_q;
  state_t               r_state, w_nxt;
  logic [TW-1:0]        r_tmr, w_tmr_nxt;
  logic                 r_step, r_sel, w_step_nxt, w_sel_nxt;

  assign w_raw = {btn_dn, btn_up};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    updown_cmd_gen_db #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_raw  (w_raw[i]),
      .o_sync (w_sync[i]),
      .o_db   (w_db[i])
    );
  end

  // Register the debounced levels once more; this stage sets the press-to-step
  // latency and gives the previous level for rise detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl   <= '0;
      r_lvl_q <= '0;
    end else begin
      r_lvl   <= w_db;
      r_lvl_q <= r_lvl;
    end
  end

  // A press only counts if the synchronized input is still high when the
  // debounced rise reaches the FSM, which rejects pulses that merely
  // outlasted the debounce window by a cycle or two.
  assign w_rise  = r_lvl & ~r_lvl_q;
  assign w_press = w_rise & w_sync;

  // State, timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_step  <= 1'b0;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_tmr   <= w_tmr_nxt;
      r_step  <= w_step_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // Next-state and timer: opposite button wins over release, release wins over timer expiry.
  always_comb begin
    w_nxt     = r_state;
    w_tmr_nxt = '0;
    case (r_state)
      S_IDLE: begin
        if (&r_lvl)          w_nxt = S_LOCK;
        else if (w_press[0]) w_nxt = S_UP_HOLD;
        else if (w_press[1]) w_nxt = S_DN_HOLD;
      end
      S_UP_HOLD: begin
        if (r_lvl[1])                w_nxt = S_LOCK;
        else if (!r_lvl[0])          w_nxt = S_IDLE;
        else if (r_tmr == HOLD_LAST) w_nxt = S_UP_RPT;
        else                         w_tmr_nxt = r_tmr + 1'b1;
      end
      S_DN_HOLD: begin
        if (r_lvl[0])                w_nxt = S_LOCK;
        else if (!r_lvl[1])          w_nxt = S_IDLE;
        else if (r_tmr == HOLD_LAST) w_nxt = S_DN_RPT;
        else                         w_tmr_nxt = r_tmr + 1'b1;
      end
      S_UP_RPT: begin
        if (r_lvl[1])               w_nxt = S_LOCK;
        else if (!r_lvl[0])         w_nxt = S_IDLE;
        else if (r_tmr != RPT_LAST) w_tmr_nxt = r_tmr + 1'b1;
      end
      S_DN_RPT: begin
        if (r_lvl[0])               w_nxt = S_LOCK;
        else if (!r_lvl[1])         w_nxt = S_IDLE;
        else if (r_tmr != RPT_LAST) w_tmr_nxt = r_tmr + 1'b1;
      end
      S_LOCK: begin
        if (r_lvl == '0) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Step/direction for the next cycle; sel only moves together with a step.
  always_comb begin
    w_step_nxt = 1'b0;
    w_sel_nxt  = r_sel;
    case (r_state)
      S_IDLE: begin
        if (!(&r_lvl)) begin
          if (w_press[0]) begin
            w_step_nxt = 1'b1;
            w_sel_nxt  = 1'b0;
          end else if (w_press[1]) begin
            w_step_nxt = 1'b1;
            w_sel_nxt  = 1'b1;
          end
        end
      end
      S_UP_HOLD: if (r_lvl == 2'b01 && r_tmr == HOLD_LAST) begin
        w_step_nxt = 1'b1;
        w_sel_nxt  = 1'b0;
      end
      S_DN_HOLD: if (r_lvl == 2'b10 && r_tmr == HOLD_LAST) begin
        w_step_nxt = 1'b1;
        w_sel_nxt  = 1'b1;
      end
      S_UP_RPT: if (r_lvl == 2'b01 && r_tmr == RPT_LAST) begin
        w_step_nxt = 1'b1;
        w_sel_nxt  = 1'b0;
      end
      S_DN_RPT: if (r_lvl == 2'b10 && r_tmr == RPT_LAST) begin
        w_step_nxt = 1'b1;
        w_sel_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  assign step   = r_step;
  assign sel    = r_sel;
  assign locked = (r_state == S_LOCK);
endmodule

// File: tb/tb_updown_cmd_gen.sv
// Bench for updown_cmd_gen: directed scenarios plus randomized presses, each
// cycle compared against step/sel/locked predicted from press timing arithmetic.
module tb_updown_cmd_gen;
  localparam int DB   = 16;
  localparam int HOLD = 64;
  localparam int RPT  = 16;
  localparam int LAT  = DB + 3;

  logic clk = 1'b0;
  logic rst_n, btn_up, btn_dn;
  logic sel, step, locked;

  int checks = 0;
  int errors = 0;
  logic exp_sel;

  updown_cmd_gen #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_up (btn_up),
    .btn_dn (btn_dn),
    .sel    (sel),
    .step   (step),
    .locked (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s k=%0d: observed %b expected %b", tag, k, obs, expv);
    end
  endtask

  // Does a press of length len (raw high from edge 0) produce a step at edge k?
  // Steps come LAT edges after the press, then HOLD later, then every RPT,
  // and the whole train ends LAT edges after the raw release.
  function automatic bit train(input int k, input int len);
    int d;
    if (len < DB + 2) return 1'b0;
    d = k - LAT;
    if (d < 0 || d >= len) return 1'b0;
    if (d == 0) return 1'b1;
    if (d < HOLD) return 1'b0;
    return ((d - HOLD) % RPT) == 0;
  endfunction

  // Drive one scenario for n cycles (len 0 = button unused). With both
  // buttons used, up must be first and still held when down arrives.
  task automatic run_case(input int up_on, input int up_len,
                          input int dn_on, input int dn_len, input int n);
    bit two;
    int lock_k, unlock_k, up_end, dn_end;
    logic es, el;
    two      = (up_len > 0) && (dn_len > 0);
    up_end   = up_on + up_len;
    dn_end   = dn_on + dn_len;
    lock_k   = dn_on + LAT;
    unlock_k = ((up_end > dn_end) ? up_end : dn_end) + LAT;
    for (int k = 0; k < n; k++) begin
      btn_up = (k >= up_on) && (k < up_end);
      btn_dn = (k >= dn_on) && (k < dn_end);
      @(posedge clk);
      @(negedge clk);
      es = 1'b0;
      el = 1'b0;
      if (two) begin
        es = train(k - up_on, up_len) && (k < lock_k);
        el = (k >= lock_k) && (k < unlock_k);
        if (es) exp_sel = 1'b0;
      end else if (up_len > 0) begin
        es = train(k - up_on, up_len);
        if (es) exp_sel = 1'b0;
      end else if (dn_len > 0) begin
        es = train(k - dn_on, dn_len);
        if (es) exp_sel = 1'b1;
      end
      chk("step", k, step, es);
      chk("sel", k, sel, exp_sel);
      chk("locked", k, locked, el);
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
  endtask

  initial begin
    int L, n, ul, don, dl;
    logic es;
    rst_n  = 1'b0;
    btn_up = 1'b1;
    btn_dn = 1'b0;
    exp_sel = 1'b0;

    // Reset state, buttons wiggling while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_step", 0, step, 1'b0);
    chk("rst_sel", 0, sel, 1'b0);
    chk("rst_locked", 0, locked, 1'b0);
    btn_dn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_step", 1, step, 1'b0);
    chk("rst_locked", 1, locked, 1'b0);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    rst_n  = 1'b1;
    run_case(0, 0, 0, 0, 8);

    // Single tap, long hold with repeat, glitches and the shortest accepted pulse.
    run_case(0, 40, 0, 0, 100);
    run_case(0, 0, 0, 200, 260);
    run_case(0, 1, 0, 0, 40);
    run_case(0, 5, 0, 0, 40);
    run_case(0, 17, 0, 0, 60);
    run_case(0, 0, 0, 17, 60);
    run_case(0, 18, 0, 0, 60);

    // Conflict mid-repeat, then a clean down press; then simultaneous press.
    run_case(0, 130, 100, 50, 220);
    run_case(0, 0, 0, 40, 100);
    run_case(0, 40, 0, 40, 100);

    // Randomized single presses and conflicts.
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        ul  = $urandom_range(60, 200);
        don = $urandom_range(1, ul - 1);
        dl  = $urandom_range(DB + 2, 150);
        n   = ((ul > don + dl) ? ul : don + dl) + LAT + 30;
        run_case(0, ul, don, dl, n);
      end else begin
        L = ($urandom_range(0, 1) == 1) ? $urandom_range(1, DB + 1)
                                        : $urandom_range(DB + 2, 220);
        n = L + LAT + $urandom_range(20, 50);
        if ($urandom_range(0, 1) == 1) run_case(0, 0, 0, L, n);
        else                           run_case(0, L, 0, 0, n);
      end
    end

    // Reset mid-repeat right after a step: outputs drop at once, then a fresh press.
    btn_dn = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      es = train(k, 1000);
      if (es) exp_sel = 1'b1;
      chk("pre_rst_step", k, step, es);
      chk("pre_rst_sel", k, sel, exp_sel);
    end
    rst_n = 1'b0;
    #1;
    chk("async_step", 0, step, 1'b0);
    chk("async_sel", 0, sel, 1'b0);
    chk("async_locked", 0, locked, 1'b0);
    exp_sel = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_case(0, 0, 0, 120, 220);

    // Reset while locked.
    run_case(0, 40, 0, 40, 30);
    chk("pre_rst_locked", 0, locked, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_locked", 1, locked, 1'b0);
    exp_sel = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_case(0, 0, 0, 0, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
